// File: rtl/fft_r22sdf_ctrl.sv
// Sequencing controller for a radix-2^2 SDF FFT pipeline.
// Counts accepted samples and decodes per-stage butterfly selects, the -j
// rotation enable, twiddle ROM addresses, and output framing signals.
// Every decoded output is a pure function of the cnt/fill registers plus en_i,
// so a gap (en_i low) freezes the whole pipeline view in place.
module fft_r22sdf_ctrl #(
    parameter int N_LOG2    = 10,
    parameter int STAGE_LAT = 2,
    parameter int BF_LAT    = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic                                 clear_i,
    output logic                                 ce_o,
    output logic [N_LOG2/2-1:0]                  bfi_sel_o,
    output logic [N_LOG2/2-1:0]                  bfii_sel_o,
    output logic [N_LOG2/2-1:0]                  bfii_negj_o,
    output logic [(N_LOG2/2-1)*N_LOG2-1:0]       tw_addr_o,
    output logic                                 valid_o,
    output logic                                 frame_start_o,
    output logic [N_LOG2-1:0]                    out_idx_o,
    output logic [N_LOG2-1:0]                    out_bin_o
);

    localparam int S    = N_LOG2 / 2;
    localparam int N    = 1 << N_LOG2;
    // Enabled cycles until the first sample of a frame reaches the last stage output.
    localparam int FILL = N - 1 + S * STAGE_LAT;
    localparam int FW   = $clog2(FILL + 1);

    localparam logic [FW-1:0]     FILL_CNT = FW'(FILL);
    localparam logic [N_LOG2-1:0] FILL_MOD = N_LOG2'(FILL % N);

    logic [N_LOG2-1:0] cnt;
    logic [FW-1:0]     fill;
    logic              valid;

    // Sample counter and saturating fill counter; clear beats a coincident en_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt  <= '0;
            fill <= '0;
        end else if (clear_i) begin
            cnt  <= '0;
            fill <= '0;
        end else if (en_i) begin
            cnt <= cnt + 1'b1;
            if (fill != FILL_CNT) begin
                fill <= fill + 1'b1;
            end
        end
    end

    assign ce_o          = en_i;
    assign valid         = (fill == FILL_CNT);
    assign valid_o       = valid;
    assign out_idx_o     = valid ? (cnt - FILL_MOD) : '0;
    assign frame_start_o = valid & en_i & (out_idx_o == '0);

    // Frequency bin is the bit-reversed output position.
    always_comb begin
        out_bin_o = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            out_bin_o[i] = out_idx_o[N_LOG2-1-i];
        end
    end

    // Per-stage decode. Stage s only looks at the low HI+1 bits of its
    // delayed count, so the subtraction is done at that width (still mod N).
    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int HI    = N_LOG2 - 1 - 2 * s;
        localparam int LO    = N_LOG2 - 2 - 2 * s;
        localparam int OFF_I = (s * STAGE_LAT) % (1 << (HI + 1));
        localparam int BF_I  = BF_LAT % (1 << (HI + 1));

        logic [HI:0] c_s;

        assign c_s            = cnt[HI:0] - OFF_I[HI:0];
        assign bfi_sel_o[s]   = c_s[HI];
        assign bfii_sel_o[s]  = c_s[LO];
        assign bfii_negj_o[s] = c_s[HI] & c_s[LO];

        if (s < S - 1) begin : g_tw
            logic [HI:0]       t;
            logic [1:0]        q;
            logic [N_LOG2-1:0] qx;
            logic [N_LOG2-1:0] kx;

            // Twiddle index lags the butterfly by BF_LAT; q is the bit-reversed
            // butterfly pair {hi,lo}, k the position within the sub-block.
            assign t  = c_s - BF_I[HI:0];
            assign q  = {t[LO], t[HI]};
            assign qx = {{(N_LOG2-2){1'b0}}, q};
            assign kx = {{(N_LOG2-LO){1'b0}}, t[LO-1:0]};
            assign tw_addr_o[s*N_LOG2 +: N_LOG2] = (qx * kx) << (2 * s);
        end
    end

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Self-checking bench for fft_r22sdf_ctrl with N_LOG2=4 (S=2, FILL=19).
module tb_fft_r22sdf_ctrl;

    localparam int NL   = 4;
    localparam int SL   = 2;
    localparam int BL   = 1;
    localparam int S    = NL / 2;
    localparam int N    = 1 << NL;
    localparam int FILL = N - 1 + S * SL;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              en_i;
    logic              clear_i;
    logic              ce_o;
    logic [S-1:0]      bfi_sel_o;
    logic [S-1:0]      bfii_sel_o;
    logic [S-1:0]      bfii_negj_o;
    logic [(S-1)*NL-1:0] tw_addr_o;
    logic              valid_o;
    logic              frame_start_o;
    logic [NL-1:0]     out_idx_o;
    logic [NL-1:0]     out_bin_o;

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;
    int m_fill = 0;

    fft_r22sdf_ctrl #(.N_LOG2(NL), .STAGE_LAT(SL), .BF_LAT(BL)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .clear_i       (clear_i),
        .ce_o          (ce_o),
        .bfi_sel_o     (bfi_sel_o),
        .bfii_sel_o    (bfii_sel_o),
        .bfii_negj_o   (bfii_negj_o),
        .tw_addr_o     (tw_addr_o),
        .valid_o       (valid_o),
        .frame_start_o (frame_start_o),
        .out_idx_o     (out_idx_o),
        .out_bin_o     (out_bin_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int n;
        int bfi, bfii, negj, tw, valid, idx, bin, fs;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int md(input int x);
        return ((x % N) + N) % N;
    endfunction

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < NL; i++) r |= ((x >> i) & 1) << (NL - 1 - i);
        return r;
    endfunction

    // Reference: decode straight from the arithmetic definitions.
    task automatic model_check(input string tag);
        int e_bfi = 0, e_bfii = 0, e_negj = 0, e_tw = 0;
        int e_valid, e_idx, e_fs;
        for (int s = 0; s < S; s++) begin
            int c, hi, lo, h, l;
            c  = md(m_cnt - s * SL);
            hi = NL - 1 - 2 * s;
            lo = NL - 2 - 2 * s;
            h  = (c >> hi) & 1;
            l  = (c >> lo) & 1;
            e_bfi  |= h << s;
            e_bfii |= l << s;
            e_negj |= (h & l) << s;
            if (s < S - 1) begin
                int t, q, k;
                t = md(c - BL);
                q = 2 * ((t >> lo) & 1) + ((t >> hi) & 1);
                k = t % (1 << lo);
                e_tw |= (((q * k) << (2 * s)) % N) << (s * NL);
            end
        end
        e_valid = (m_fill == FILL) ? 1 : 0;
        e_idx   = e_valid ? md(m_cnt - FILL) : 0;
        e_fs    = (e_valid == 1 && en_i && e_idx == 0) ? 1 : 0;
        chk({tag, ".ce"},    int'(ce_o),          int'(en_i));
        chk({tag, ".bfi"},   int'(bfi_sel_o),     e_bfi);
        chk({tag, ".bfii"},  int'(bfii_sel_o),    e_bfii);
        chk({tag, ".negj"},  int'(bfii_negj_o),   e_negj);
        chk({tag, ".tw"},    int'(tw_addr_o),     e_tw);
        chk({tag, ".valid"}, int'(valid_o),       e_valid);
        chk({tag, ".idx"},   int'(out_idx_o),     e_idx);
        chk({tag, ".bin"},   int'(out_bin_o),     brev(e_idx));
        chk({tag, ".fs"},    int'(frame_start_o), e_fs);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        en_i    = 1'b0;
        clear_i = 1'b0;
        m_cnt   = 0;
        m_fill  = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One cycle: drive at negedge, check, optional async reset pulse, then clock.
    task automatic step(input bit en, input bit clr, input bit rpulse, input string tag);
        en_i    = en;
        clear_i = clr;
        #1;
        model_check(tag);
        if (rpulse) begin
            rst_i = 1'b1;
            #1;
            m_cnt  = 0;
            m_fill = 0;
            model_check({tag, ".rst"});
            rst_i = 1'b0;
            #1;
        end
        @(posedge clk_i);
        if (clr) begin
            m_cnt  = 0;
            m_fill = 0;
        end else if (en) begin
            m_cnt = md(m_cnt + 1);
            if (m_fill < FILL) m_fill++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b0;
        clear_i = 1'b0;

        // Hand-derived decode after n enabled cycles from reset (en_i held high).
        vecs[0]  = '{0,  2, 0, 0, 9, 0, 0, 0, 0};
        vecs[1]  = '{4,  2, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{5,  2, 3, 2, 0, 0, 0, 0, 0};
        vecs[3]  = '{6,  0, 1, 0, 2, 0, 0, 0, 0};
        vecs[4]  = '{8,  3, 0, 0, 6, 0, 0, 0, 0};
        vecs[5]  = '{10, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{14, 1, 1, 1, 3, 0, 0, 0, 0};
        vecs[7]  = '{18, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{19, 0, 2, 0, 0, 1, 0, 0, 1};
        vecs[9]  = '{20, 2, 1, 0, 0, 1, 1, 8, 0};
        vecs[10] = '{35, 0, 2, 0, 0, 1, 0, 0, 1};

        for (int v = 0; v < 11; v++) begin
            do_reset();
            en_i = 1'b1;
            repeat (vecs[v].n) @(negedge clk_i);
            #1;
            chk($sformatf("vec%0d.bfi", vecs[v].n),   int'(bfi_sel_o),     vecs[v].bfi);
            chk($sformatf("vec%0d.bfii", vecs[v].n),  int'(bfii_sel_o),    vecs[v].bfii);
            chk($sformatf("vec%0d.negj", vecs[v].n),  int'(bfii_negj_o),   vecs[v].negj);
            chk($sformatf("vec%0d.tw", vecs[v].n),    int'(tw_addr_o),     vecs[v].tw);
            chk($sformatf("vec%0d.valid", vecs[v].n), int'(valid_o),       vecs[v].valid);
            chk($sformatf("vec%0d.idx", vecs[v].n),   int'(out_idx_o),     vecs[v].idx);
            chk($sformatf("vec%0d.bin", vecs[v].n),   int'(out_bin_o),     vecs[v].bin);
            chk($sformatf("vec%0d.fs", vecs[v].n),    int'(frame_start_o), vecs[v].fs);
            en_i = 1'b0;
        end

        // Gaps: 1,0,0,1 advances the count by exactly two, holding on idle cycles.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, "gap_pre");
        step(1'b1, 1'b0, 1'b0, "gap1");
        step(1'b0, 1'b0, 1'b0, "gap0a");
        step(1'b0, 1'b0, 1'b0, "gap0b");
        step(1'b1, 1'b0, 1'b0, "gap1b");
        chk("gap_cnt", m_cnt, 5);
        step(1'b0, 1'b0, 1'b0, "gap_post");

        // Async reset between edges at cnt=7 of the second frame.
        do_reset();
        repeat (23) step(1'b1, 1'b0, 1'b0, "mrst_pre");
        en_i = 1'b1;
        #1;
        chk("mrst_valid_before", int'(valid_o), 1);
        rst_i = 1'b1;
        #1;
        chk("mrst_valid_now", int'(valid_o), 0);
        chk("mrst_idx_now", int'(out_idx_o), 0);
        chk("mrst_bfi_now", int'(bfi_sel_o), 2);
        rst_i  = 1'b0;
        m_cnt  = 0;
        m_fill = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        m_cnt  = 2;
        m_fill = 2;
        step(1'b0, 1'b0, 1'b0, "mrst_post");

        // Clear together with en at cnt=5: sample dropped, count restarts at 0.
        do_reset();
        repeat (5) step(1'b1, 1'b0, 1'b0, "clr_pre");
        step(1'b1, 1'b1, 1'b0, "clr_edge");
        chk("clr_bfi", int'(bfi_sel_o), 2);
        step(1'b1, 1'b0, 1'b0, "clr_post0");
        step(1'b0, 1'b0, 1'b0, "clr_post1");

        // Wrap: 40 consecutive enabled cycles, frame_start at cycles 20 and 36.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            en_i = 1'b1;
            #1;
            chk($sformatf("wrap_fs%0d", k), int'(frame_start_o), (k == 20 || k == 36) ? 1 : 0);
            step(1'b1, 1'b0, 1'b0, "wrap");
        end

        // Randomized traffic with occasional clear and async reset pulses.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) == 0,
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
